// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-Lite slave that fronts a single-ported 32-bit SRAM. Every beat is
//   decoded on its own; burst type is ignored. A configurable number of wait
//   states is inserted into every data phase. Without the error option,
//   misaligned low address bits are forced into alignment. The word index
//   wraps modulo DEPTH_WORDS.
//
//   Optional feature macro: AHB_SLAVE_ERROR_RESP_EN
//     When defined, the slave answers with a two-cycle ERROR response for
//     these transfers: an out-of-range word index, an hsize above word, a
//     misaligned half, or a misaligned word. Such a transfer makes no
//     memory access.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words. Must be a power of two, >= 2.
//   WAIT_STATES : extra low-HREADY cycles per data phase (0..15).
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : synchronous active-high reset
//   i_hsel     : slave select
//   i_haddr    : byte address
//   i_htrans   : IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
//   i_hwrite   : 1 = write
//   i_hsize    : 000 byte, 001 half, 010 word
//   i_hburst   : accepted and ignored
//   i_hwdata   : write data, little-endian lanes
//   i_hready   : bus HREADY (end of previous data phase)
//   o_hrdata   : read data, valid while o_hready=1 in a read data phase
//   o_hready   : this slave's HREADY
//   o_hresp    : 00 OKAY, 01 ERROR
//   o_state    : current FSM state, for debug observation
//
// Handshake: an address phase is taken on a rising edge where
// i_hsel & i_hready & i_htrans[1] is high. Its data phase ends on the first
// later rising edge where o_hready=1. A new address phase may be taken on
// that same edge, so transfers pipeline back to back.

module ahb_sram_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic [1:0]  i_htrans,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic [2:0]  i_hburst,
    input  logic [31:0] i_hwdata,
    input  logic        i_hready,
    output logic [31:0] o_hrdata,
    output logic        o_hready,
    output logic [1:0]  o_hresp,
    output logic [1:0]  o_state
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;

    // Latched address phase
    logic             phase_vld_q, phase_vld_d;
    logic             hwrite_q;
    logic [2:0]       hsize_q;
    logic [1:0]       addr_lo_q;
    logic [IDX_W-1:0] idx_q;

    logic [31:0]      rdata_q;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             take;
    logic             addr_err;
    logic [IDX_W-1:0] a_idx;
    logic [3:0]       be;
    logic             wr_fire;
    logic [31:0]      rd_word;

    // These address bits only matter when the range check is compiled in.
    // The burst type and the BUSY/IDLE distinction are never needed.
    logic unused_ok;
    assign unused_ok = ^{i_hburst, i_htrans[0], i_haddr[31:IDX_W+2]};

    assign a_idx = i_haddr[IDX_W+1:2];

    // Address phases are only taken while no data phase is stalled or
    // erroring. One taken in S_ERR2 is dropped.
    assign take = i_hsel & i_hready & i_htrans[1] & (state_q == S_IDLE);

    always_comb begin
        addr_err = 1'b0;
`ifdef AHB_SLAVE_ERROR_RESP_EN
        if (i_haddr[31:2] >= 30'(DEPTH_WORDS)) addr_err = 1'b1;
        if (i_hsize > 3'b010)                  addr_err = 1'b1;
        if ((i_hsize == 3'b001) && i_haddr[0]) addr_err = 1'b1;
        if ((i_hsize == 3'b010) && (i_haddr[1:0] != 2'b00)) addr_err = 1'b1;
`endif
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (take) begin
                    if (addr_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LAST;
                    end
                end
            end
            S_WAIT: begin
                // The counter holds the number of low cycles left after this one
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            S_ERR2:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_hready = 1'b1;
        o_hresp  = RESP_OKAY;
        case (state_q)
            S_WAIT: o_hready = 1'b0;
            S_ERR1: begin
                o_hready = 1'b0;
                o_hresp  = RESP_ERROR;
            end
            S_ERR2:  o_hresp = RESP_ERROR;
            default: ;
        endcase
    end

    assign o_state  = state_q;
    assign o_hrdata = rdata_q;

    // ------------------------------------------------------------------
    // Latched address phase. In S_IDLE a pending phase completes this
    // cycle, so the valid flag is simply replaced by the new take.
    // ------------------------------------------------------------------
    always_comb begin
        phase_vld_d = 1'b0;
        case (state_q)
            S_IDLE:  phase_vld_d = take & ~addr_err;
            S_WAIT:  phase_vld_d = phase_vld_q;
            default: phase_vld_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_vld_q <= 1'b0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b000;
            addr_lo_q   <= 2'b00;
            idx_q       <= '0;
        end else begin
            phase_vld_q <= phase_vld_d;
            if (take) begin
                hwrite_q  <= i_hwrite;
                hsize_q   <= i_hsize;
                addr_lo_q <= i_haddr[1:0];
                idx_q     <= a_idx;
            end
        end
    end

    // Lane enables. A half picks its lane pair from addr[1] only, and any
    // size above half writes the whole word. This forces alignment when
    // error responses are not compiled in.
    always_comb begin
        be = 4'b1111;
        case (hsize_q)
            3'b000:  be = 4'b0001 << addr_lo_q;
            3'b001:  be = addr_lo_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // The write data phase closes in S_IDLE with a valid latched phase
    assign wr_fire = phase_vld_q & hwrite_q & (state_q == S_IDLE) & ~reset;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx_q][8*b +: 8] <= i_hwdata[8*b +: 8];
            end
        end
    end

    // A read taken while a write to the same word completes sees the new
    // bytes (write-first forwarding).
    always_comb begin
        rd_word = mem[a_idx];
        for (int b = 0; b < 4; b++) begin
            if (wr_fire && be[b] && (idx_q == a_idx)) begin
                rd_word[8*b +: 8] = i_hwdata[8*b +: 8];
            end
        end
    end

    // The read word is registered at the take edge, which covers a
    // zero-wait data phase. During wait states it is refreshed from the
    // latched index, so the value is current when o_hready rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 32'd0;
        end else if (take) begin
            rdata_q <= rd_word;
        end else if (state_q == S_WAIT) begin
            rdata_q <= mem[idx_q];
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave
//   Bench for ahb_sram_slave. Three instances run with WAIT_STATES of 0, 3
//   and 5. A byte-addressed reference memory gives the expected data. The
//   bench covers reset values, directed transfers, a reset abort, and a
//   randomized mix of single transfers and write-then-read pairs.
//   Optional feature macro: AHB_SLAVE_ERROR_RESP_EN (the expectations follow it).

module tb_ahb_sram_slave;

    localparam int N     = 3;
    localparam int DEPTH = 1024;
`ifdef AHB_SLAVE_ERROR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int ws [N] = '{0, 3, 5};

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0] hsel;
    logic [N-1:0] hwrite;
    logic [N-1:0] hready_o;
    logic [1:0]   htrans  [N];
    logic [31:0]  haddr   [N];
    logic [2:0]   hsize   [N];
    logic [2:0]   hburst  [N];
    logic [31:0]  hwdata  [N];
    logic [31:0]  hrdata  [N];
    logic [1:0]   hresp   [N];
    logic [1:0]   st      [N];

    ahb_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .i_hsel(hsel[0]), .i_haddr(haddr[0]),
        .i_htrans(htrans[0]), .i_hwrite(hwrite[0]), .i_hsize(hsize[0]),
        .i_hburst(hburst[0]), .i_hwdata(hwdata[0]), .i_hready(hready_o[0]),
        .o_hrdata(hrdata[0]), .o_hready(hready_o[0]), .o_hresp(hresp[0]),
        .o_state(st[0]));

    ahb_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut1 (
        .clk(clk), .reset(reset), .i_hsel(hsel[1]), .i_haddr(haddr[1]),
        .i_htrans(htrans[1]), .i_hwrite(hwrite[1]), .i_hsize(hsize[1]),
        .i_hburst(hburst[1]), .i_hwdata(hwdata[1]), .i_hready(hready_o[1]),
        .o_hrdata(hrdata[1]), .o_hready(hready_o[1]), .o_hresp(hresp[1]),
        .o_state(st[1]));

    ahb_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(5)) dut2 (
        .clk(clk), .reset(reset), .i_hsel(hsel[2]), .i_haddr(haddr[2]),
        .i_htrans(htrans[2]), .i_hwrite(hwrite[2]), .i_hsize(hsize[2]),
        .i_hburst(hburst[2]), .i_hwdata(hwdata[2]), .i_hready(hready_o[2]),
        .o_hrdata(hrdata[2]), .o_hready(hready_o[2]), .o_hresp(hresp[2]),
        .o_state(st[2]));

    // ------------------------------------------------------------------
    // Scoreboard state and reference model
    // ------------------------------------------------------------------
    int cmp_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_q [$];
    logic [7:0]  mdl [N][DEPTH*4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic [2:0] sz, input logic [31:0] a);
        bit bad;
        bad = ((a / 4) >= DEPTH) || (sz > 3'd2) ||
              ((sz == 3'd1) && (a % 2 != 0)) || ((sz == 3'd2) && (a % 4 != 0));
        return ERR_EN && bad;
    endfunction

    function automatic logic [31:0] model_word(input int k, input logic [31:0] a);
        int unsigned base;
        base = ((a / 4) % DEPTH) * 4;
        return {mdl[k][base+3], mdl[k][base+2], mdl[k][base+1], mdl[k][base]};
    endfunction

    // Writes n = 1/2/4 bytes at the address rounded down to n, inside a
    // memory that wraps every DEPTH*4 bytes. Byte b takes write-data lane b%4.
    task automatic model_write(input int k, input logic [2:0] sz, input logic [31:0] a,
                               input logic [31:0] wd);
        int unsigned n;
        int unsigned ba;
        n  = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
        ba = a % (DEPTH * 4);
        ba = ba - (ba % n);
        for (int i = 0; i < n; i++) begin
            mdl[k][ba+i] = wd[8*((ba+i)%4) +: 8];
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (entered and left just after a falling edge)
    // ------------------------------------------------------------------
    task automatic idle_bus(input int k);
        hsel[k]   = 1'b0;
        htrans[k] = 2'b00;
        hwrite[k] = 1'b0;
        hsize[k]  = 3'b010;
        haddr[k]  = 32'd0;
        hburst[k] = 3'b000;
        hwdata[k] = 32'd0;
    endtask

    task automatic xfer(input int k, input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output int lows,
                        output logic [1:0] resp_low, output logic [1:0] resp_end);
        hsel[k]   = 1'b1;
        htrans[k] = 2'b10;
        hwrite[k] = wr;
        hsize[k]  = sz;
        haddr[k]  = addr;
        hburst[k] = 3'($urandom_range(0, 7));
        @(negedge clk);
        hsel[k]   = 1'b0;
        htrans[k] = 2'b00;
        hwdata[k] = wd;
        lows      = 0;
        resp_low  = 2'b00;
        while (hready_o[k] !== 1'b1 && lows < 64) begin
            if (lows == 0) resp_low = hresp[k];
            lows++;
            @(negedge clk);
        end
        rd       = hrdata[k];
        resp_end = hresp[k];
        @(negedge clk);
    endtask

    // Write address phase, then a read address phase overlapping its data phase
    task automatic b2b(input int k, input logic [2:0] wsz, input logic [31:0] waddr,
                       input logic [31:0] wd, input logic [31:0] raddr,
                       output logic [31:0] rd, output int lows);
        int guard;
        hsel[k]   = 1'b1;
        htrans[k] = 2'b10;
        hwrite[k] = 1'b1;
        hsize[k]  = wsz;
        haddr[k]  = waddr;
        @(negedge clk);
        hwrite[k] = 1'b0;
        hsize[k]  = 3'b010;
        haddr[k]  = raddr;
        hwdata[k] = wd;
        guard = 0;
        while (hready_o[k] !== 1'b1 && guard < 64) begin
            guard++;
            @(negedge clk);
        end
        @(negedge clk);
        hsel[k]   = 1'b0;
        htrans[k] = 2'b00;
        lows = guard;
        while (hready_o[k] !== 1'b1 && lows < 128) begin
            lows++;
            @(negedge clk);
        end
        rd = hrdata[k];
        @(negedge clk);
    endtask

    // Single transfer checked against the model: wait count, response, read data
    task automatic do_op(input int k, input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input string tag, output logic [31:0] rd,
                         output logic [1:0] re);
        int lows;
        logic [1:0] rl;
        bit err;
        logic [31:0] exp_w;
        err = model_err(sz, addr);
        exp_q.push_back(model_word(k, addr));
        xfer(k, wr, sz, addr, wd, rd, lows, rl, re);
        exp_w = exp_q.pop_front();
        chk({tag, "_waits"}, lows, err ? 1 : ws[k]);
        chk({tag, "_resp_low"}, 32'(rl), err ? 32'd1 : 32'd0);
        chk({tag, "_resp"}, 32'(re), err ? 32'd1 : 32'd0);
        if (!wr && !err) chk({tag, "_rdata"}, rd, exp_w);
        if (wr && !err) model_write(k, sz, addr, wd);
    endtask

    task automatic do_b2b(input int k, input logic [2:0] wsz, input logic [31:0] waddr,
                          input logic [31:0] wd, input logic [31:0] raddr, input string tag,
                          output logic [31:0] rd);
        int lows;
        logic [31:0] exp_w;
        model_write(k, wsz, waddr, wd);
        exp_q.push_back(model_word(k, raddr));
        b2b(k, wsz, waddr, wd, raddr, rd, lows);
        exp_w = exp_q.pop_front();
        chk({tag, "_waits"}, lows, 2 * ws[k]);
        chk({tag, "_rdata"}, rd, exp_w);
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed then random sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] rd;
        logic [1:0]  re;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  sz;
        int          k;
        int          lows;

        reset = 1'b1;
        for (int i = 0; i < N; i++) idle_bus(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("reset_hready%0d", i), 32'(hready_o[i]), 32'd1);
            chk($sformatf("reset_hresp%0d", i), 32'(hresp[i]), 32'd0);
            chk($sformatf("reset_hrdata%0d", i), hrdata[i], 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Give every instance a known 16-word window
        for (int i = 0; i < N; i++) begin
            for (int w = 0; w < 16; w++) begin
                do_op(i, 1'b1, 3'b010, 32'(w * 4), $urandom, "preload", rd, re);
            end
        end

        // Word write then read, zero wait
        do_op(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "w10", rd, re);
        do_op(0, 1'b0, 3'b010, 32'h10, 32'h0, "r10", rd, re);
        chk("r10_const", rd, 32'hDEADBEEF);

        // Byte and half merge into a zeroed word
        do_op(0, 1'b1, 3'b010, 32'h20, 32'h0, "w20", rd, re);
        do_op(0, 1'b1, 3'b000, 32'h21, 32'h0000AA00, "wb21", rd, re);
        do_op(0, 1'b1, 3'b001, 32'h22, 32'h12340000, "wh22", rd, re);
        do_op(0, 1'b0, 3'b010, 32'h20, 32'h0, "r20", rd, re);
        chk("r20_const", rd, 32'h1234AA00);

        // Three wait states on a single read
        do_op(1, 1'b0, 3'b010, 32'h10, 32'h0, "ws3_read", rd, re);

        // Back-to-back write then read of the same word
        do_b2b(0, 3'b010, 32'h40, 32'h11223344, 32'h40, "b2b0", rd);
        chk("b2b0_const", rd, 32'h11223344);
        do_b2b(1, 3'b010, 32'h40, 32'h55667788, 32'h40, "b2b1", rd);
        chk("b2b1_const", rd, 32'h55667788);

        // Out-of-range read
        do_op(0, 1'b1, 3'b010, 32'h0, 32'h0BADF00D, "w0", rd, re);
        do_op(0, 1'b0, 3'b010, 32'h1000, 32'h0, "r1000", rd, re);
`ifdef AHB_SLAVE_ERROR_RESP_EN
        chk("r1000_err", 32'(re), 32'd1);
`else
        chk("r1000_alias", rd, 32'h0BADF00D);
`endif

        // Reset during the second wait cycle of a write aborts it
        do_op(2, 1'b1, 3'b010, 32'h8, 32'h5555AAAA, "w8_pre", rd, re);
        hsel[2]   = 1'b1;
        htrans[2] = 2'b10;
        hwrite[2] = 1'b1;
        hsize[2]  = 3'b010;
        haddr[2]  = 32'h8;
        @(negedge clk);
        idle_bus(2);
        hwdata[2] = 32'hCAFEF00D;
        chk("abort_wait1_low", 32'(hready_o[2]), 32'd0);
        @(negedge clk);
        chk("abort_wait2_low", 32'(hready_o[2]), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_hready", 32'(hready_o[2]), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        do_op(2, 1'b0, 3'b010, 32'h8, 32'h0, "r8_after_abort", rd, re);
        chk("r8_const", rd, 32'h5555AAAA);

        // Randomized mix
        for (int it = 0; it < 60; it++) begin
            k = $urandom_range(0, N - 1);
            case ($urandom_range(0, 2))
                0: begin
                    a = 32'($urandom_range(0, 63));
                    if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
                    do_op(k, 1'b1, 3'($urandom_range(0, 3)), a, $urandom, "rnd_wr", rd, re);
                end
                1: begin
                    a = 32'($urandom_range(0, 63));
                    if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
                    do_op(k, 1'b0, 3'($urandom_range(0, 3)), a, 32'h0, "rnd_rd", rd, re);
                end
                default: begin
                    sz = 3'($urandom_range(0, 2));
                    a  = 32'($urandom_range(0, 63));
                    if (sz == 3'b001) a = a & ~32'd1;
                    if (sz == 3'b010) a = a & ~32'd3;
                    d = $urandom;
                    if ($urandom_range(0, 3) == 0) begin
                        do_b2b(k, sz, a, d, 32'($urandom_range(0, 15) * 4), "rnd_b2b", rd);
                    end else begin
                        do_b2b(k, sz, a, d, a & ~32'd3, "rnd_fwd", rd);
                    end
                end
            endcase
        end

        lows = exp_q.size();
        chk("scoreboard_drained", 32'(lows), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words; power of two.
REQ-002 SHALL have parameter WAIT_STATES, default 0: extra low-HREADY cycles per data phase, 0..15.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-005 SHALL have port i_hsel, input, 1: slave select.
REQ-006 SHALL have port i_haddr, input, 32: byte address.
REQ-007 SHALL have port i_htrans, input, 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 SHALL have port i_hwrite, input, 1: 1 = write.
REQ-009 SHALL have port i_hsize, input, 3: 000 = byte, 001 = half, 010 = word.
REQ-010 SHALL have port i_hburst, input, 3: accepted and ignored; each beat is addressed independently.
REQ-011 SHALL have port i_hwdata, input, 32: write data, little-endian lanes.
REQ-012 SHALL have port i_hready, input, 1: bus HREADY, marks the end of the previous data phase.
REQ-013 SHALL have port o_hrdata, output, 32: read data.
REQ-014 SHALL have port o_hready, output, 1: this slave's HREADY.
REQ-015 SHALL have port o_hresp, output, 2: 00 = OKAY, 01 = ERROR.

Function
REQ-016 SHALL accept an address phase when i_hsel & i_hready & i_htrans[1] in the same cycle, and latch haddr, hwrite and hsize.
REQ-017 SHALL answer IDLE, BUSY or unselected cycles with zero wait and OKAY, and SHALL NOT access memory for them.
REQ-018 SHALL implement FSM states S_IDLE, S_WAIT, S_ERR1, S_ERR2.
REQ-019 On an accepted transfer, SHALL go to S_WAIT when WAIT_STATES > 0; otherwise the next cycle is the final data-phase cycle.
REQ-020 In S_WAIT, SHALL hold o_hready=0 and o_hresp=OKAY for exactly WAIT_STATES cycles (down-counter), then drive o_hready=1.
REQ-021 Data-phase latency SHALL be 1 + WAIT_STATES cycles after address-phase acceptance.
REQ-022 Writes SHALL update memory in the cycle where o_hready=1 closes the data phase.
REQ-023 Write byte enables SHALL come from the latched size and addr[1:0]: byte = 1 lane; half = lanes {1:0} or {3:2}; word = all lanes.
REQ-024 Reads SHALL present the full addressed word on o_hrdata when o_hready=1; o_hrdata is don't-care otherwise.
REQ-025 A read whose address phase overlaps the data phase of a write to the same word SHALL return the newly written bytes (bypass or write-first).
REQ-026 SHALL accept a new address phase in the same cycle that the previous data phase completes (pipelined back-to-back).
REQ-027 hsize > 010 SHALL be treated as word unless REQ-034 applies.
REQ-028 In S_ERR1, SHALL drive o_hready=0 and o_hresp=01; in S_ERR2, o_hready=1 and o_hresp=01.
REQ-029 An address phase accepted during S_ERR2 SHALL be ignored; the FSM then returns to S_IDLE.
REQ-030 SHALL perform no memory write on an ERROR response.

Reset
REQ-031 While reset=1 at a clock edge, SHALL set state=S_IDLE, wait counter=0, o_hready=1, o_hresp=00, o_hrdata=0, and clear the latched phase.
REQ-032 Reset during S_WAIT or S_ERR1 SHALL abort the transfer with no memory write; memory contents are not initialised or cleared.

Configuration
REQ-033 SHALL use macro AHB_SLAVE_ERROR_RESP_EN.
REQ-034 With AHB_SLAVE_ERROR_RESP_EN defined, SHALL give a two-cycle ERROR (S_ERR1 then S_ERR2, skipping wait states) in these cases:
- word index >= DEPTH_WORDS;
- hsize > 010;
- half with addr[0]=1;
- word with addr[1:0] != 00.
REQ-035 Without the macro, SHALL never drive ERROR, SHALL compute the word index modulo DEPTH_WORDS, and SHALL ignore misaligned low address bits (force alignment).

Verification
REQ-036 WAIT_STATES=0: NONSEQ word write 0x0000_0010 = 0xDEADBEEF, then a read of the same address -> read data 0xDEADBEEF, o_hready never low, o_hresp=00.
REQ-037 Byte writes 0xAA to address 0x21 and half 0x1234 to address 0x22 over a word preloaded 0 -> word read at 0x20 returns 0x1234AA00.
REQ-038 WAIT_STATES=3: single read -> o_hready low for exactly 3 cycles, then high with data.
REQ-039 Back-to-back write 0x0000_0040 = 0x11223344 followed immediately by a read of 0x40 -> 0x11223344.
REQ-040 With macro, DEPTH_WORDS=1024: read 0x0000_1000 -> cycle 1 {o_hready=0, o_hresp=01}, cycle 2 {o_hready=1, o_hresp=01}; without macro, the same read returns word 0 with OKAY.
REQ-041 WAIT_STATES=5: reset asserted in the 2nd wait cycle of a write of 0xCAFEF00D to 0x8 -> o_hready=1 next cycle, word 0x8 keeps its prior value.
